io_scan_ctrl: RTL and testbench

IO_SCAN_CTRL -- requirements
Module: io_scan_ctrl

---
 rtl/io_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_io_scan_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_scan_ctrl.sv
// Memory-mapped I/O block: 8-digit multiplexed 7-segment scanner, debounced buttons, switch readback.
// Registers at 0x80-0x8F: DISP, CFG (digit enable / dp mask), STAT (W1C press-pending), SW.
module io_scan_ctrl #(
  parameter int SCAN_DIV  = 4,
  parameter int DB_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        writeEN,
  input  logic [31:0] dataAdr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ioHit,
  input  logic        btnL,
  input  logic        btnR,
  input  logic [15:0] switch,
  output logic [7:0]  an,
  output logic [6:0]  a2g,
  output logic        dp
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DB_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_DISP = 2'd0,
    REG_CFG  = 2'd1,
    REG_STAT = 2'd2,
    REG_SW   = 2'd3
  } reg_sel_e;

  logic [31:0]     r_disp;
  logic [15:0]     r_cfg;
  logic [1:0]      r_btn_s1, r_btn_s2, r_deb, r_pend;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [15:0]     r_sw_s1, r_sw_s2;
  logic [DIV_W-1:0] r_div;
  logic [2:0]      r_idx;
  logic [7:0]      r_an;
  logic [6:0]      r_a2g;
  logic            r_dp;

  reg_sel_e   w_sel;
  logic       w_wr;
  logic [1:0] w_db_take, w_db_rise, w_w1c;
  logic [3:0] w_digit;
  logic       w_unused_adr;

  assign ioHit        = (dataAdr[31:4] == 28'h0000008);
  assign w_sel        = reg_sel_e'(dataAdr[3:2]);
  assign w_wr         = writeEN && ioHit;
  assign w_w1c        = (w_wr && w_sel == REG_STAT) ? writeData[1:0] : 2'b00;
  assign w_digit      = r_disp[{r_idx, 2'b00} +: 4];
  assign w_unused_adr = ^dataAdr[1:0];

  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // A button change is accepted on the DB_CYCLES-th consecutive differing sample.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_db_take[b] = (r_btn_s2[b] != r_deb[b]) && (r_db_cnt[b] == DB_LAST);
    end
  end
  assign w_db_rise = w_db_take & r_btn_s2;

  // NOTE: every register below uses <= so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_deb    <= '0;
      r_pend   <= '0;
      // NOTE: the counter array is reset element by element; a stale count would skew the first debounce.
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      r_btn_s1 <= {btnR, btnL};
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= switch;
      r_sw_s2  <= r_sw_s1;
      for (int b = 0; b < 2; b++) begin
        if (r_btn_s2[b] == r_deb[b]) begin
          r_db_cnt[b] <= '0;
        end else if (w_db_take[b]) begin
          r_deb[b]    <= r_btn_s2[b];
          r_db_cnt[b] <= '0;
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
      // A new press wins over a simultaneous software clear.
      r_pend <= (r_pend & ~w_w1c) | w_db_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp <= '0;
      r_cfg  <= 16'h00FF;
    end else if (w_wr) begin
      if (w_sel == REG_DISP) r_disp <= writeData;
      if (w_sel == REG_CFG)  r_cfg  <= writeData[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_idx <= '0;
      r_an  <= 8'hFF;
      r_a2g <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
      r_an  <= r_cfg[r_idx] ? ~(8'h01 << r_idx) : 8'hFF;
      r_a2g <= hex_to_seg(w_digit);
      r_dp  <= ~r_cfg[{1'b1, r_idx}];
    end
  end

  assign an  = r_an;
  assign a2g = r_a2g;
  assign dp  = r_dp;

  // NOTE: readData gets its default first so no path through the decode can infer a latch.
  always_comb begin
    readData = '0;
    if (ioHit) begin
      case (w_sel)
        REG_DISP: readData = r_disp;
        REG_CFG:  readData = {16'h0000, r_cfg};
        REG_STAT: readData = {28'h0, r_deb, r_pend};
        REG_SW:   readData = {16'h0000, r_sw_s2};
      endcase
    end
  end
endmodule

// File: tb/tb_io_scan_ctrl.sv
// Scoreboard bench for io_scan_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_io_scan_ctrl;
  typedef enum int {OBS_RD, OBS_HIT, OBS_AN, OBS_A2G, OBS_DP} obs_e;
  typedef struct {
    obs_e        obs;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  logic        clk = 1'b0;
  logic        reset, writeEN, btnL, btnR, ioHit, dp;
  logic [31:0] dataAdr, writeData, readData;
  logic [15:0] switch;
  logic [7:0]  an;
  logic [6:0]  a2g;

  io_scan_ctrl #(.SCAN_DIV(4), .DB_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .writeEN(writeEN), .dataAdr(dataAdr),
    .writeData(writeData), .readData(readData), .ioHit(ioHit),
    .btnL(btnL), .btnR(btnR), .switch(switch),
    .an(an), .a2g(a2g), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input obs_e o, input logic [31:0] v, input string nm);
    exp_t e;
    e.obs  = o;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic read_exp(input logic [31:0] adr, input logic [31:0] v, input string nm);
    dataAdr = adr;
    push_exp(OBS_RD, v, nm);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.obs)
        OBS_RD:  act = readData;
        OBS_HIT: act = {31'h0, ioHit};
        OBS_AN:  act = {24'h0, an};
        OBS_A2G: act = {25'h0, a2g};
        default: act = {31'h0, dp};
      endcase
      check(e.name, act, e.exp);
    end
  end

  initial begin
    logic [7:0]  e_an;
    logic [15:0] cfg_m;
    logic [31:0] disp_m;
    logic [3:0]  dig;
    int          idx;

    reset = 1'b1; writeEN = 1'b0; dataAdr = '0; writeData = '0;
    btnL = 1'b0; btnR = 1'b0; switch = '0;
    tick(3);
    push_exp(OBS_AN, 32'hFF, "rst_an");
    push_exp(OBS_A2G, 32'h7F, "rst_a2g");
    push_exp(OBS_DP, 32'h1, "rst_dp");
    read_exp(32'h80, 32'h0, "rst_disp");
    tick(1);
    read_exp(32'h84, 32'hFF, "rst_cfg");
    tick(1);

    // Idle scan with default configuration: every digit enabled, all showing "0".
    reset = 1'b0;
    tick(1);
    for (int c = 0; c < 40; c++) begin
      e_an = ~(8'h01 << ((c / 4) % 8));
      push_exp(OBS_AN, {24'h0, e_an}, "idle_an");
      push_exp(OBS_A2G, 32'h40, "idle_a2g");
      push_exp(OBS_DP, 32'h1, "idle_dp");
      if (c == 0) read_exp(32'h88, 32'h0, "idle_stat");
      tick(1);
    end

    // DISP/CFG programming; CFG upper half discarded, mid-scan CFG rewrite keeps the scan phase.
    reset = 1'b1;
    tick(2);
    reset = 1'b0; writeEN = 1'b1; dataAdr = 32'h80; writeData = 32'h0123ABCD;
    tick(1);
    dataAdr = 32'h84; writeData = 32'h000100F0;
    tick(1);
    writeEN = 1'b0;
    read_exp(32'h80, 32'h0123ABCD, "disp_rb");
    tick(1);
    disp_m = 32'h0123ABCD;
    for (int c = 2; c < 36; c++) begin
      cfg_m = (c >= 21) ? 16'h01F0 : 16'h00F0;
      idx   = (c / 4) % 8;
      dig   = disp_m[idx*4 +: 4];
      e_an  = cfg_m[idx] ? ~(8'h01 << idx) : 8'hFF;
      push_exp(OBS_AN, {24'h0, e_an}, "disp_an");
      push_exp(OBS_A2G, {25'h0, seg_of(dig)}, "disp_a2g");
      push_exp(OBS_DP, {31'h0, ~cfg_m[8 + idx]}, "disp_dp");
      if (c == 2)  read_exp(32'h84, 32'h000000F0, "cfg_rb");
      if (c == 19) begin writeEN = 1'b1; dataAdr = 32'h84; writeData = 32'h000001F0; end
      if (c == 20) writeEN = 1'b0;
      if (c == 21) read_exp(32'h84, 32'h000001F0, "cfg_rb2");
      tick(1);
    end

    // Left button: 2 sync + 8 debounce edges, then W1C of pending.
    btnL = 1'b1; dataAdr = 32'h88;
    tick(9);
    read_exp(32'h88, 32'h0, "dbL_before");
    tick(1);
    read_exp(32'h88, 32'h5, "dbL_after");
    tick(10);
    writeEN = 1'b1; writeData = 32'h0000000D;
    tick(1);
    writeEN = 1'b0;
    read_exp(32'h88, 32'h4, "stat_w1c");
    btnL = 1'b0;
    tick(12);
    read_exp(32'h88, 32'h0, "dbL_release");
    tick(1);

    // Bouncing right button never stays stable long enough.
    for (int k = 0; k < 30; k++) begin
      btnR = ((k / 3) % 2 == 0);
      if (k % 5 == 4) read_exp(32'h88, 32'h0, "bounceR");
      tick(1);
    end
    btnR = 1'b0;
    tick(12);
    read_exp(32'h88, 32'h0, "bounceR_end");
    tick(1);

    // W1C on the very edge pending L sets: set wins.
    btnL = 1'b1;
    tick(9);
    writeEN = 1'b1; dataAdr = 32'h88; writeData = 32'h1;
    tick(1);
    writeEN = 1'b0;
    read_exp(32'h88, 32'h5, "w1c_vs_set");
    tick(1);
    read_exp(32'h88, 32'h5, "w1c_vs_set_hold");
    tick(1);

    // Reset during a debounce in progress abandons it.
    btnL = 1'b0;
    tick(12);
    btnL = 1'b1;
    tick(6);
    reset = 1'b1;
    tick(1);
    read_exp(32'h88, 32'h0, "rst_mid_stat");
    push_exp(OBS_AN, 32'hFF, "rst_mid_an");
    push_exp(OBS_DP, 32'h1, "rst_mid_dp");
    reset = 1'b0;
    tick(9);
    read_exp(32'h88, 32'h0, "abandon_before");
    tick(1);
    read_exp(32'h88, 32'h5, "abandon_after");
    tick(1);

    // Switch synchronizer latency, read-only SW, address decode.
    switch = 16'hA5A5;
    read_exp(32'h8C, 32'h0, "sw_0cyc");
    tick(1);
    read_exp(32'h8C, 32'h0, "sw_1cyc");
    tick(1);
    read_exp(32'h8C, 32'h0000A5A5, "sw_2cyc");
    push_exp(OBS_HIT, 32'h1, "hit_8c");
    tick(1);
    read_exp(32'h8F, 32'h0000A5A5, "sw_byteoff");
    tick(1);
    writeEN = 1'b1; dataAdr = 32'h8C; writeData = 32'hFFFFFFFF;
    tick(1);
    writeEN = 1'b0;
    read_exp(32'h8C, 32'h0000A5A5, "sw_ro");
    tick(1);
    read_exp(32'h100, 32'h0, "miss_rd");
    push_exp(OBS_HIT, 32'h0, "miss_hit");
    tick(1);
    read_exp(32'h7C, 32'h0, "miss_rd_7c");
    push_exp(OBS_HIT, 32'h0, "miss_hit_7c");
    tick(1);
    read_exp(32'h90, 32'h0, "miss_rd_90");
    push_exp(OBS_HIT, 32'h0, "miss_hit_90");
    tick(2);

    if (q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
